mod_demod_gen_v3: RTL and testbench

MOD_DEMOD_GEN_V3 -- requirements
Module: mod_demod_gen_v3

---
 rtl/mod_demod_gen_v3.sv | 147 ++++++++++++++
 tb/tb_mod_demod_gen_v3.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mod_demod_gen_v3.sv
// mod_demod_gen_v3: square-wave modulator with synchronous boxcar demodulator and saturating error output
module mod_demod_gen_v3 #(
   parameter int ADC_W        = 14,
   parameter int MOD_W        = 32,
   parameter int AVG_MAX_LOG2 = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_en,
   input  logic [31:0]             i_freq_cnt,
   input  logic signed [MOD_W-1:0] i_amp_H,
   input  logic signed [MOD_W-1:0] i_amp_L,
   input  logic [15:0]             i_settle_cnt,
   input  logic [3:0]              i_avg_log2,
   input  logic                    i_polarity,
   input  logic signed [31:0]      i_err_offset,
   input  logic signed [ADC_W-1:0] i_adc_data,
   output logic [MOD_W-1:0]        o_mod_out,
   output logic                    o_status,
   output logic                    o_stepTrig,
   output logic [31:0]             o_err,
   output logic                    o_err_vld,
   output logic                    o_short,
   output logic                    o_sat
);
   localparam int ACC_W = ADC_W + AVG_MAX_LOG2 + 1;
   localparam int EW    = (ACC_W + 2 > 34) ? ACC_W + 2 : 34;
   localparam int CW    = AVG_MAX_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, SETTLE, ACC, HOLD} state_t;

   state_t                  r_state;
   logic [31:0]             r_cnt, r_len;
   logic [3:0]              r_n;
   logic [15:0]             r_set, r_scnt;
   logic [CW-1:0]           r_acnt;
   logic signed [ACC_W-1:0] r_acc, r_sum_h;
   logic                    r_vh;
   logic                    r_status, r_step, r_vld, r_short, r_sat;
   logic [MOD_W-1:0]        r_mod_out;
   logic [31:0]             r_err;

   logic                    w_run, w_bnd, w_last, w_done, w_ovf;
   logic [31:0]             w_len, w_err;
   logic [3:0]              w_n;
   logic signed [ACC_W-1:0] w_sample, w_sum;
   logic signed [EW-1:0]    w_diff, w_d, w_e;

   // IDLE doubles as "not running"; the boundary is the last count of the half
   assign w_run    = r_state != IDLE;
   assign w_bnd    = w_run && (r_cnt == r_len - 32'd1);
   assign w_len    = (i_freq_cnt < 32'd2) ? 32'd2 : i_freq_cnt;
   assign w_n      = (i_avg_log2 > 4'(AVG_MAX_LOG2)) ? 4'(AVG_MAX_LOG2) : i_avg_log2;
   assign w_sample = {{(ACC_W-ADC_W){i_adc_data[ADC_W-1]}}, i_adc_data};
   assign w_last   = r_acnt == ((CW'(1) << r_n) - CW'(1));
   // a half also completes when its last sample lands exactly on the boundary cycle
   assign w_done   = (r_state == HOLD) || (r_state == ACC && w_last);
   assign w_sum    = (r_state == HOLD) ? r_acc : r_acc + w_sample;
   assign w_diff   = EW'(r_sum_h) - EW'(w_sum);
   assign w_d      = w_diff >>> r_n;
   assign w_e      = (i_polarity ? -w_d : w_d) + EW'(i_err_offset);
   assign w_ovf    = ~(&w_e[EW-1:31] | ~|w_e[EW-1:31]);
   assign w_err    = w_ovf ? (w_e[EW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : w_e[31:0];

   // half-period timing, demodulator FSM and all registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_len     <= '0;
         r_n       <= '0;
         r_set     <= '0;
         r_scnt    <= '0;
         r_acnt    <= '0;
         r_acc     <= '0;
         r_sum_h   <= '0;
         r_vh      <= 1'b0;
         r_status  <= 1'b0;
         r_step    <= 1'b0;
         r_vld     <= 1'b0;
         r_short   <= 1'b0;
         r_sat     <= 1'b0;
         r_mod_out <= '0;
         r_err     <= '0;
      end else begin
         r_step  <= 1'b0;
         r_vld   <= 1'b0;
         r_short <= 1'b0;
         if (!i_en) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_status  <= 1'b0;
            r_mod_out <= '0;
            r_vh      <= 1'b0;
            r_acc     <= '0;
         end else if (!w_run || w_bnd) begin
            r_cnt     <= '0;
            r_len     <= w_len;
            r_n       <= w_n;
            r_set     <= i_settle_cnt;
            r_scnt    <= '0;
            r_acnt    <= '0;
            r_acc     <= '0;
            r_state   <= (i_settle_cnt == 16'd0) ? ACC : SETTLE;
            r_status  <= w_run ? ~r_status : 1'b0;
            r_mod_out <= (w_run && !r_status) ? i_amp_H : i_amp_L;
            if (w_bnd) begin
               r_short <= !w_done;
               if (r_status) begin
                  r_vh    <= w_done;
                  r_sum_h <= w_sum;
               end else begin
                  r_step <= 1'b1;
                  r_vh   <= 1'b0;
                  if (w_done && r_vh) begin
                     r_vld <= 1'b1;
                     r_err <= w_err;
                     r_sat <= w_ovf;
                  end
               end
            end
         end else begin
            r_cnt <= r_cnt + 32'd1;
            case (r_state)
               SETTLE: begin
                  r_scnt <= r_scnt + 16'd1;
                  if (r_scnt == r_set - 16'd1) r_state <= ACC;
               end
               ACC: begin
                  r_acc  <= w_sum;
                  r_acnt <= r_acnt + CW'(1);
                  if (w_last) r_state <= HOLD;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_mod_out  = r_mod_out;
   assign o_status   = r_status;
   assign o_stepTrig = r_step;
   assign o_err      = r_err;
   assign o_err_vld  = r_vld;
   assign o_short    = r_short;
   assign o_sat      = r_sat;
endmodule

// File: tb/tb_mod_demod_gen_v3.sv
// tb_mod_demod_gen_v3: directed vector table plus multi-cycle corner sequences
module tb_mod_demod_gen_v3;
   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               en = 1'b0;
   logic [31:0]        freq = 32'd10;
   logic signed [31:0] amp_h = 32'sh1234_5678;
   logic signed [31:0] amp_l = -32'sd7;
   logic [15:0]        settle = 16'd2;
   logic [3:0]         avg = 4'd2;
   logic               pol = 1'b0;
   logic signed [31:0] off = 32'sd5;
   logic signed [13:0] adc_h = 14'sd100, adc_l = -14'sd100;
   logic signed [13:0] adc;
   logic [31:0]        mod_out, err;
   logic               status, step, vld, shrt, sat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // ADC follows the modulation the DUT is driving
   assign adc = status ? adc_h : adc_l;

   mod_demod_gen_v3 dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_freq_cnt(freq),
      .i_amp_H(amp_h), .i_amp_L(amp_l), .i_settle_cnt(settle),
      .i_avg_log2(avg), .i_polarity(pol), .i_err_offset(off),
      .i_adc_data(adc), .o_mod_out(mod_out), .o_status(status),
      .o_stepTrig(step), .o_err(err), .o_err_vld(vld),
      .o_short(shrt), .o_sat(sat)
   );

   typedef struct {
      logic [31:0]        freq;
      logic [15:0]        settle;
      logic [3:0]         avg;
      logic               pol;
      logic [31:0]        off;
      logic signed [13:0] ah, al;
      logic [31:0]        err;
      logic               sat;
      int                 first;
      int                 period;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_vld(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vld && n < budget);
      if (!vld) begin
         checks++;
         errors++;
         $display("FAIL vld_timeout: no o_err_vld within %0d cycles", budget);
      end
   endtask

   task automatic wait_status(input logic v);
      int n = 0;
      while (status !== v && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("status_wait", 32'(status), 32'(v));
   endtask

   task automatic half_len(output int n);
      logic v = status;
      n = 0;
      while (status === v && n < 100) begin
         n++;
         if (n == 3) freq = 32'd4;
         @(negedge clk);
      end
   endtask

   initial begin
      int n, ns, nv;
      logic [31:0] last_err;
      logic        last_sat;
      vt[0] = '{32'd10,  16'd2, 4'd2,  1'b0, 32'd5,          14'sd100, -14'sd100, 32'd205,         1'b0, 31,  20};
      vt[1] = '{32'd10,  16'd2, 4'd2,  1'b1, 32'd5,          14'sd100, -14'sd100, -32'sd195,       1'b0, 31,  20};
      vt[2] = '{32'd10,  16'd2, 4'd2,  1'b0, 32'h7FFF_FFF0,  14'sd100, -14'sd100, 32'h7FFF_FFFF,   1'b1, 31,  20};
      vt[3] = '{32'd10,  16'd2, 4'd2,  1'b0, 32'd0,          14'sd100, -14'sd100, 32'd200,         1'b0, 31,  20};
      vt[4] = '{32'd0,   16'd0, 4'd1,  1'b0, 32'd1,          14'sd100, -14'sd100, 32'd201,         1'b0, 7,   4};
      vt[5] = '{32'd300, 16'd2, 4'd15, 1'b0, 32'd7,          14'sd100, -14'sd100, 32'd207,         1'b0, 901, 600};
      vt[6] = '{32'd1,   16'd0, 4'd0,  1'b1, -32'sd3,        14'sd100, -14'sd100, -32'sd203,       1'b0, 7,   4};
      vt[7] = '{32'd8,   16'd1, 4'd1,  1'b0, 32'd0,          -14'sd50, 14'sd31,   -32'sd81,        1'b0, 25,  16};
      vt[8] = '{32'd10,  16'd2, 4'd2,  1'b1, 32'h8000_0000,  14'sd100, -14'sd100, 32'h8000_0000,   1'b1, 31,  20};

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mod", mod_out, 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_err", err, 32'd0);
      chk("rst_pulses", 32'({step, vld, shrt, sat}), 32'd0);
      rst_n = 1'b1;
      last_err = 32'd0;
      last_sat = 1'b0;

      for (int i = 0; i < 9; i++) begin
         en = 1'b0;
         freq = vt[i].freq; settle = vt[i].settle; avg = vt[i].avg;
         pol = vt[i].pol; off = vt[i].off; adc_h = vt[i].ah; adc_l = vt[i].al;
         repeat (2) @(negedge clk);
         chk("dis_status", 32'(status), 32'd0);
         chk("dis_mod", mod_out, 32'd0);
         chk("dis_err_hold", err, last_err);
         chk("dis_sat_hold", 32'(sat), 32'(last_sat));
         en = 1'b1;
         wait_vld(vt[i].first + vt[i].period + 20, n);
         chk("first_vld_lat", 32'(n), 32'(vt[i].first));
         chk("err", err, vt[i].err);
         chk("sat", 32'(sat), 32'(vt[i].sat));
         chk("step_with_vld", 32'(step), 32'd1);
         chk("mod_high", mod_out, amp_h);
         @(negedge clk);
         chk("vld_one_clk", 32'(vld), 32'd0);
         wait_vld(vt[i].period + 20, n);
         chk("period", 32'(n + 1), 32'(vt[i].period));
         chk("err_repeat", err, vt[i].err);
         last_err = vt[i].err;
         last_sat = vt[i].sat;
      end

      // short halves: every boundary flags o_short, no error update
      en = 1'b0; freq = 32'd10; settle = 16'd8; avg = 4'd2; pol = 1'b0; off = 32'd5;
      adc_h = 14'sd100; adc_l = -14'sd100;
      repeat (2) @(negedge clk);
      en = 1'b1;
      ns = 0; nv = 0;
      repeat (101) begin
         @(negedge clk);
         ns += int'(shrt);
         nv += int'(vld);
      end
      chk("short_count", 32'(ns), 32'd10);
      chk("short_no_vld", 32'(nv), 32'd0);
      chk("short_err_hold", err, last_err);
      chk("short_sat_hold", 32'(sat), 32'(last_sat));

      // freq change mid-half applies only from the next half
      en = 1'b0; settle = 16'd2;
      repeat (2) @(negedge clk);
      en = 1'b1;
      wait_status(1'b1);
      half_len(n);
      chk("half_before_change", 32'(n), 32'd10);
      half_len(n);
      chk("half_after_change", 32'(n), 32'd4);
      half_len(n);
      chk("half_next", 32'(n), 32'd4);

      // asynchronous reset in the middle of accumulation
      en = 1'b0; freq = 32'd10;
      repeat (2) @(negedge clk);
      en = 1'b1;
      wait_status(1'b1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_status", 32'(status), 32'd0);
      chk("arst_mod", mod_out, 32'd0);
      chk("arst_err", err, 32'd0);
      chk("arst_flags", 32'({step, vld, shrt, sat}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_vld(60, n);
      chk("arst_first_vld", 32'(n), 32'd31);
      chk("arst_err_val", err, 32'd205);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
